// File: rtl/timestamp_pkg.sv
// Shared definitions for the BCD timestamp block: digit width, BCD limit and
// the digit type used by the decade counters and the top level.
package timestamp_pkg;

   localparam int unsigned DIGIT_W = 4;

   typedef logic [DIGIT_W-1:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD decade (0..9) with synchronous clear and carry-in increment.
// Ports:
//   clk, reset (async, active-low), clear (sync, wins over inc),
//   inc (carry in), digit (current decade value), at_max (digit == 9).
module bcd_digit_counter
   import timestamp_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       inc,
   output bcd_digit_t digit,
   output logic       at_max
);

   // Decade register: wraps 9 -> 0 on increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         digit <= '0;
      end else if (clear) begin
         digit <= '0;
      end else if (inc) begin
         digit <= (digit == BCD_MAX) ? '0 : digit + DIGIT_W'(1);
      end
   end

   assign at_max = (digit == BCD_MAX);

endmodule

// File: rtl/bcd_timestamp_capture.sv
// Parametrised BCD chronometer with prescaler, run/stop, sync clear, sticky
// overflow and per-channel timestamp capture with valid/ack handshake.
// Ports:
//   clk, reset (async, active-low)
//   enable   - run/hold for prescaler and digits
//   clear    - sync clear of time, prescaler, overflow and cap_lost
//   trig     - per-channel level triggers, rising edge captures time
//   cap_ack  - per-channel consumer acknowledge
//   time_out - live BCD time, digit k at [4k+3:4k]
//   tick     - prescaler strobe
//   overflow - sticky wrap flag
//   cap_valid, cap_time, cap_lost - per-channel capture state
module bcd_timestamp_capture
   import timestamp_pkg::*;
#(
   parameter int unsigned N_DIGITS = 12,
   parameter int unsigned PRESCALE = 5,
   parameter int unsigned N_CH     = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic                           clear,
   input  logic [N_CH-1:0]                trig,
   input  logic [N_CH-1:0]                cap_ack,
   output logic [DIGIT_W*N_DIGITS-1:0]    time_out,
   output logic                           tick,
   output logic                           overflow,
   output logic [N_CH-1:0]                cap_valid,
   output logic [N_CH*DIGIT_W*N_DIGITS-1:0] cap_time,
   output logic [N_CH-1:0]                cap_lost
);

   localparam int unsigned TW   = DIGIT_W * N_DIGITS;
   localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PS_W-1:0]     ps_cnt;
   logic                ps_last;
   logic                tick_int;
   logic [N_DIGITS:0]   carry;
   logic [N_DIGITS-1:0] at_max;

   assign ps_last  = (ps_cnt == PS_W'(PRESCALE - 1));
   assign tick_int = enable & ps_last;
   // Gated by reset so the strobe is low while reset is held, even for PRESCALE=1.
   assign tick     = tick_int & reset;

   // Prescaler: 0..PRESCALE-1 while enabled, holds otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ps_cnt <= '0;
      end else if (clear) begin
         ps_cnt <= '0;
      end else if (enable) begin
         ps_cnt <= ps_last ? '0 : ps_cnt + PS_W'(1);
      end
   end

   // Carry chain is purely combinational so every decade updates on the same edge.
   assign carry[0] = tick_int;

   for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
      bcd_digit_t digit_q;

      bcd_digit_counter u_digit (
         .clk    (clk),
         .reset  (reset),
         .clear  (clear),
         .inc    (carry[k]),
         .digit  (digit_q),
         .at_max (at_max[k])
      );

      assign carry[k+1]                  = carry[k] & at_max[k];
      assign time_out[k*DIGIT_W +: DIGIT_W] = digit_q;
   end

   // Sticky overflow: carry out of the top decade means all digits wrapped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
      end else if (clear) begin
         overflow <= 1'b0;
      end else if (carry[N_DIGITS]) begin
         overflow <= 1'b1;
      end
   end

   // Per-channel capture; clear only touches the lost flag.
   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic          trig_d;
      logic          trig_edge;
      logic          valid_q;
      logic          lost_q;
      logic [TW-1:0] cap_q;

      assign trig_edge = trig[c] & ~trig_d;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            trig_d  <= 1'b0;
            valid_q <= 1'b0;
            lost_q  <= 1'b0;
            cap_q   <= '0;
         end else begin
            trig_d <= trig[c];
            if (trig_edge) begin
               // An ack in the same cycle frees the register for the new sample.
               if (!valid_q || cap_ack[c]) begin
                  cap_q   <= time_out;
                  valid_q <= 1'b1;
               end else begin
                  lost_q <= 1'b1;
               end
            end else if (cap_ack[c] && valid_q) begin
               valid_q <= 1'b0;
            end
            if (clear) begin
               lost_q <= 1'b0;
            end
         end
      end

      assign cap_valid[c]          = valid_q;
      assign cap_lost[c]           = lost_q;
      assign cap_time[c*TW +: TW]  = cap_q;
   end

endmodule

// File: doc/bcd_timestamp_capture.md
# bcd_timestamp_capture

Parametrised successor to the fixed 12-decade BCD chronometer. It counts decimal time in a configurable number of BCD digits, driven by a configurable clock prescaler. It adds run/stop and synchronous-clear control, sticky overflow, and per-channel timestamp capture with a valid/ack handshake. It sits between the detector trigger logic and the readout/UART packer, providing event time tags in the BCD format the readout already expects.

## Interface
Parameters:
- `N_DIGITS`, 12 — number of BCD decades; output width is 4·N_DIGITS.
- `PRESCALE`, 5 — clk cycles per least-significant-digit tick (≥1; 1 means a tick every enabled cycle).
- `N_CH`, 2 — number of independent capture channels (≥1).

Ports:
- `clk` in 1 — single system clock.
- `reset` in 1 — asynchronous, active-low reset.
- `enable` in 1 — run (1) / hold (0); the prescaler and digits freeze while low.
- `clear` in 1 — synchronous clear of time, prescaler, overflow and lost flags.
- `trig` in N_CH — capture requests, synchronous to clk, level; the rising edge is detected internally.
- `cap_ack` in N_CH — consumer acknowledge, one per channel.
- `time_out` out 4·N_DIGITS — live BCD time; digit k occupies bits [4k+3:4k].
- `tick` out 1 — one-cycle prescaler strobe, for monitoring.
- `overflow` out 1 — sticky; set when the time wraps from all-9s to 0.
- `cap_valid` out N_CH — capture register holds unread data.
- `cap_time` out N_CH·4·N_DIGITS — captured time; channel c occupies slice [c·4·N_DIGITS +: 4·N_DIGITS].
- `cap_lost` out N_CH — sticky; an edge arrived while `cap_valid` was high and not acked.

## Operation
- **Reset** (`reset`=0, asynchronous): every output and internal register goes to 0, including the trig edge-detect flops.
- **Prescaler**: counts 0…PRESCALE-1 while `enable`=1. `tick`=1 in the cycle where count==PRESCALE-1 and `enable`=1; the counter returns to 0 in that cycle. When `enable`=0 the prescaler holds its value and `tick`=0.
- **Digit k** increments on `tick` when all lower digits equal 9. A digit at 9 that increments wraps to 0.
  - The carry is computed combinationally within the cycle, so all digits update on the same edge. There is no ripple lag between decades.
  - Digit values are always in 0–9.
- **Overflow**: on a `tick` with all digits at 9, every digit wraps to 0 and `overflow` sets. It stays set until `clear` or reset.
- **Clear** has priority over `tick` and `enable`. The next edge zeroes the digits, prescaler, `overflow` and `cap_lost`. `cap_valid` and `cap_time` are not affected.
- **Capture, channel c**:
  - Edge detection: `trig_d` is registered, and `edge` = `trig & ~trig_d`.
  - On `edge`, `cap_time` loads the `time_out` value present in that same cycle (the pre-increment value) and `cap_valid` is set.
  - An `edge` while `cap_valid`=1 and `cap_ack`=0 leaves `cap_time` unchanged, keeps `cap_valid`=1 and sets `cap_lost`.
  - An `edge` and `cap_ack` in the same cycle while valid: the new capture is accepted, `cap_valid` stays 1, and `cap_lost` is not set.
  - `cap_ack` with `cap_valid`=1 and no `edge` clears `cap_valid` on the next edge. `cap_ack` while not valid is ignored.
- **Clear and edge in the same cycle**: the capture takes the pre-clear `time_out` value.
- Channels are fully independent of one another.

## Timing
- `time_out` changes on the clock edge ending a `tick` cycle. Tick-to-`time_out` latency is 1 cycle.
- Trigger edge to valid capture: the trig rise is sampled at edge n, and `cap_valid`/`cap_time` are updated after edge n+1. This is 1 cycle of latency from the sampled rise.
- `overflow` is set on the same edge as the wrap.
- `clear` takes effect 1 cycle after it is asserted. A `clear` held for multiple cycles keeps the time at 0.
- Reset deassertion mid-run restarts everything from 0. The first possible `tick` comes PRESCALE enabled cycles later.

## Structure
- Shared package `timestamp_pkg`: `DIGIT_W`=4, `BCD_MAX`=4'd9, and the `bcd_digit_t` typedef.
- Sub-module `bcd_digit_counter`, one instance per digit (generate loop). Ports: `clk`, `reset`, `clear`, `inc`, `digit`, `at_max`. The carry into digit k is `tick` AND all lower `at_max`.
- Capture logic is a generate loop over N_CH inside the top module. It needs no separate module.

## Test plan
Benches use N_DIGITS=4, PRESCALE=5, N_CH=2.
- **Free run**: `enable`=1 for 5·123 cycles after reset → `time_out`=16'h0123 and `tick` period = 5 cycles.
- **Hold**: drop `enable` for 17 cycles → `time_out` and the prescaler phase are unchanged; resuming gives the next `tick` after the remaining phase.
- **Wrap**: preload by running to 16'h9999, then one `tick` → `time_out`=16'h0000 and `overflow`=1 on the same edge. Then `clear` → `overflow`=0.
- **Capture/ack**: rise `trig[0]` while `time_out`=16'h0042 → one cycle later `cap_valid[0]`=1 and `cap_time[0]`=16'h0042. `cap_ack[0]` → `cap_valid[0]`=0. Channel 1 stays untouched.
- **Lost**: a second `trig[1]` edge before ack → `cap_time[1]` keeps its first value and `cap_lost[1]`=1. An edge together with ack → new value loaded and `cap_lost` unchanged.
- **Async reset mid-count**: pull `reset` low between clock edges → all outputs are 0 immediately, without waiting for a clock edge.
